// File: rtl/neuron_mac.sv
// neuron_mac: streaming multiply-accumulate front end for the sigmoid stage.
// Accepts (activation, weight) pairs through a valid/ready handshake, adds a
// per-vector bias, then rounds and saturates the sum to signed Q4.12.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid && ready are both 1. A producer holds valid and its data stable until
// that edge, and out_valid is never withdrawn without a transfer.
module neuron_mac #(
    parameter int DATA_W    = 16,
    parameter int FRAC_W    = 12,
    parameter int MAX_TERMS = 256,
    parameter int ACC_W     = 40
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    input  logic [DATA_W-1:0]              in_weight,
    input  logic                           in_last,
    input  logic [DATA_W-1:0]              bias,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_x,
    output logic                           out_sat,
    output logic                           out_ovf,
    output logic [$clog2(MAX_TERMS):0]     out_count
);

    localparam int CNT_W = $clog2(MAX_TERMS) + 1;
    localparam int PROD_W = 2 * DATA_W;

    // Clip limits and rounding constant expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] X_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] X_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] HALF  = {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic {ST_ACCUM = 1'b0, ST_OUT = 1'b1} state_t;

    state_t                     state;
    logic                       init_done;
    logic signed [PROD_W-1:0]   p;
    logic                       p_vld;
    logic                       p_last;
    logic                       p_ovf;
    logic signed [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]           count;
    logic [DATA_W-1:0]          bias_r;

    logic                       accept;
    logic [CNT_W-1:0]           n_acc;
    logic                       at_limit;
    logic signed [ACC_W-1:0]    p_ext;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    bias_sh;
    logic signed [ACC_W-1:0]    rnd;
    logic signed [ACC_W-1:0]    r;
    logic                       sat_hi;
    logic                       sat_lo;
    logic [DATA_W-1:0]          x_clip;

    // Ready / accept decode and the closing arithmetic for the term in stage 2.
    always_comb begin
        in_ready = init_done && (state == ST_ACCUM) && !(p_vld && p_last);
        accept   = in_valid && in_ready;
        // Terms already accepted in this vector (accumulated plus in flight).
        n_acc    = count + CNT_W'(p_vld);
        at_limit = (n_acc == CNT_W'(MAX_TERMS - 1));
        p_ext    = {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
        acc_next = acc + p_ext;
        bias_sh  = {{(ACC_W-DATA_W-FRAC_W){bias_r[DATA_W-1]}}, bias_r, {FRAC_W{1'b0}}};
        rnd      = acc_next + bias_sh + HALF;
        r        = rnd >>> FRAC_W;
        sat_hi   = (r > X_MAX);
        sat_lo   = (r < X_MIN);
        if (sat_hi)
            x_clip = {1'b0, {(DATA_W-1){1'b1}}};
        else if (sat_lo)
            x_clip = {1'b1, {(DATA_W-1){1'b0}}};
        else
            x_clip = r[DATA_W-1:0];
    end

    // Two-stage MAC pipeline with ACCUM/OUT control and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACCUM;
            init_done <= 1'b0;
            p         <= '0;
            p_vld     <= 1'b0;
            p_last    <= 1'b0;
            p_ovf     <= 1'b0;
            acc       <= '0;
            count     <= '0;
            bias_r    <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_sat   <= 1'b0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else begin
            init_done <= 1'b1;
            case (state)
                ST_ACCUM: begin
                    // Stage 2: fold the registered product into the sum.
                    if (p_vld) begin
                        acc   <= acc_next;
                        count <= count + CNT_W'(1);
                        if (p_last) begin
                            out_x     <= x_clip;
                            out_sat   <= sat_hi || sat_lo;
                            out_ovf   <= p_ovf;
                            out_count <= count + CNT_W'(1);
                            out_valid <= 1'b1;
                            state     <= ST_OUT;
                        end
                    end
                    // Stage 1: register the product of an accepted pair.
                    if (accept) begin
                        p      <= $signed(in_data) * $signed(in_weight);
                        p_vld  <= 1'b1;
                        p_last <= in_last || at_limit;
                        p_ovf  <= !in_last && at_limit;
                        if (n_acc == '0)
                            bias_r <= bias;
                    end else begin
                        p_vld <= 1'b0;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        count     <= '0;
                        state     <= ST_ACCUM;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed vectors for neuron_mac with hand-computed results.
module tb_neuron_mac;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] in_weight;
    logic        in_last;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;
    logic        out_sat;
    logic        out_ovf;
    logic [8:0]  out_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    neuron_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_weight (in_weight),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_sat   (out_sat),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    // Clock and free-running cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          n;
        logic [15:0] d[4];
        logic [15:0] w[4];
        logic [15:0] b;
        logic [15:0] x;
        logic        sat;
        int          hold;
    } vec_t;

    vec_t vecs[12];
    int   nv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int n,
                           input logic [15:0] d0, input logic [15:0] w0,
                           input logic [15:0] d1, input logic [15:0] w1,
                           input logic [15:0] d2, input logic [15:0] w2,
                           input logic [15:0] d3, input logic [15:0] w3,
                           input logic [15:0] b, input logic [15:0] x,
                           input logic sat, input int hold);
        vecs[nv].n = n;
        vecs[nv].d[0] = d0; vecs[nv].w[0] = w0;
        vecs[nv].d[1] = d1; vecs[nv].w[1] = w1;
        vecs[nv].d[2] = d2; vecs[nv].w[2] = w2;
        vecs[nv].d[3] = d3; vecs[nv].w[3] = w3;
        vecs[nv].b = b; vecs[nv].x = x; vecs[nv].sat = sat; vecs[nv].hold = hold;
        nv++;
    endtask

    // Present one pair and return #1 after the edge that accepts it.
    task automatic drive_beat(input logic [15:0] d, input logic [15:0] w,
                              input logic last, input logic [15:0] b);
        int waited;
        in_valid  = 1'b1;
        in_data   = d;
        in_weight = w;
        in_last   = last;
        bias      = b;
        waited    = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: in_ready stuck at 0");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called #1 after the last accepted beat: check latency, result, hold, handshake.
    task automatic expect_result(input string tag, input logic [15:0] x, input logic sat,
                                 input logic ovf, input logic [8:0] cnt, input int hold);
        int waited;
        check({tag, "_not_early"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_latency"}, 32'(out_valid), 32'd1);
        waited = 0;
        while (!out_valid && waited < 20) begin
            waited++;
            @(posedge clk);
            #1;
        end
        check({tag, "_x"}, 32'(out_x), 32'(x));
        check({tag, "_sat"}, 32'(out_sat), 32'(sat));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(ovf));
        check({tag, "_count"}, 32'(out_count), 32'(cnt));
        check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_x"}, 32'(out_x), 32'(x));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_vec(input int i);
        for (int k = 0; k < vecs[i].n; k++)
            drive_beat(vecs[i].d[k], vecs[i].w[k], (k == vecs[i].n - 1),
                       (k == 0) ? vecs[i].b : 16'h5A5A);
        expect_result($sformatf("vec%0d", i), vecs[i].x, vecs[i].sat, 1'b0,
                      9'(vecs[i].n), vecs[i].hold);
    endtask

    initial begin
        int t0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_weight = '0;
        in_last = 1'b0; bias = '0; out_ready = 1'b0;

        //        n  d0       w0       d1       w1       d2       w2       d3       w3       bias     x        sat hold
        add_vec(1, 16'h1000,16'h2000, 16'h0,16'h0, 16'h0,16'h0, 16'h0,16'h0, 16'h0000,16'h2000,1'b0,0);
        add_vec(3, 16'h1800,16'h0800, 16'hF000,16'h2000, 16'h0400,16'h0400, 16'h0,16'h0, 16'h0800,16'hF500,1'b0,5);
        add_vec(4, 16'h7000,16'h7000, 16'h7000,16'h7000, 16'h7000,16'h7000, 16'h7000,16'h7000, 16'h0000,16'h7FFF,1'b1,0);
        add_vec(1, 16'h7000,16'h8000, 16'h0,16'h0, 16'h0,16'h0, 16'h0,16'h0, 16'h0000,16'h8000,1'b1,0);
        add_vec(1, 16'h0001,16'h0800, 16'h0,16'h0, 16'h0,16'h0, 16'h0,16'h0, 16'h0000,16'h0001,1'b0,0);
        add_vec(1, 16'h0001,16'hF800, 16'h0,16'h0, 16'h0,16'h0, 16'h0,16'h0, 16'h0000,16'h0000,1'b0,0);
        add_vec(1, 16'h0003,16'h0800, 16'h0,16'h0, 16'h0,16'h0, 16'h0,16'h0, 16'h0000,16'h0002,1'b0,0);
        add_vec(1, 16'hFFFD,16'h0800, 16'h0,16'h0, 16'h0,16'h0, 16'h0,16'h0, 16'h0000,16'hFFFF,1'b0,0);
        add_vec(1, 16'h0000,16'h1234, 16'h0,16'h0, 16'h0,16'h0, 16'h0,16'h0, 16'h7FFF,16'h7FFF,1'b0,0);
        add_vec(1, 16'h0001,16'h0800, 16'h0,16'h0, 16'h0,16'h0, 16'h0,16'h0, 16'h7FFF,16'h7FFF,1'b1,0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_x", 32'(out_x), 32'd0);
        check("rst_flags", {29'd0, out_sat, out_ovf, 1'b0}, 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rst_release_ready_high", 32'(in_ready), 32'd1);

        // Table-driven vectors.
        for (int i = 0; i < nv; i++) run_vec(i);

        // Forced close at MAX_TERMS with a continuous stream.
        t0 = cyc;
        for (int k = 0; k < 256; k++) drive_beat(16'h1000, 16'h0010, 1'b0, 16'h0000);
        check("lim_stream_cycles", 32'(cyc - t0), 32'd256);
        expect_result("lim", 16'h1000, 1'b0, 1'b1, 9'd256, 0);
        drive_beat(16'h1000, 16'h1000, 1'b1, 16'h0000);
        expect_result("after_lim", 16'h1000, 1'b0, 1'b0, 9'd1, 0);

        // Reset mid-vector discards the partial sum.
        for (int k = 0; k < 3; k++) drive_beat(16'h2000, 16'h2000, 1'b0, 16'h1000);
        rst_n = 1'b0;
        #2;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_output", 32'(out_valid), 32'd0);
        drive_beat(16'h1000, 16'h1000, 1'b1, 16'h0000);
        expect_result("post_rst", 16'h1000, 1'b0, 1'b0, 9'd1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
